// File: rtl/ramdp_bist.sv
// March C- BIST engine driving one port of a single-clock dual-port RAM.
// One RAM op per cycle; each read is checked against registered dout the following cycle.
module ramdp_bist #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [DW-1:0] pattern,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [CW-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [AW-1:0] AMAX = '1;
  localparam logic [CW-1:0] CMAX = '1;

  state_t        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ph_q, ph_d;
  logic [DW-1:0] pat_q, pat_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] rd_exp_q, rd_exp_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]    rd_elem_q, rd_elem_d;
  logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;
  logic [CW-1:0] err_q, err_d;

  logic          run, is_write, down, last_op, last_addr, miscmp;
  logic [DW-1:0] wdata, rexp;

  // ph_q selects the write half of a read-then-write element
  always_comb begin
    run       = (state_q == RUN);
    is_write  = (elem_q == 3'd0) || ph_q;
    down      = (elem_q >= 3'd3);
    last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || ph_q;
    last_addr = down ? (addr_q == '0) : (addr_q == AMAX);
    wdata     = (elem_q == 3'd1 || elem_q == 3'd3) ? ~pat_q : pat_q;
    rexp      = (elem_q == 3'd2 || elem_q == 3'd4) ? ~pat_q : pat_q;
    miscmp    = rd_pend_q && (ram_dout != rd_exp_q);
  end

  assign ram_en    = run;
  assign ram_we    = run && is_write;
  assign ram_addr  = run ? addr_q : '0;
  assign ram_din   = ram_we ? wdata : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_q;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    pat_d       = pat_q;
    rd_pend_d   = 1'b0;
    rd_exp_d    = rd_exp_q;
    rd_addr_d   = rd_addr_q;
    rd_elem_d   = rd_elem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_d       = err_q;

    if (miscmp) begin
      if (err_q != CMAX) err_d = err_q + 1'b1;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = rd_addr_q;
        fail_elem_d = rd_elem_q;
      end
    end

    case (state_q)
      IDLE: if (start) begin
        pat_d       = pattern;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        fail_addr_d = '0;
        fail_elem_d = '0;
        err_d       = '0;
        busy_d      = 1'b1;
        elem_d      = '0;
        addr_d      = '0;
        ph_d        = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        if (!is_write) begin
          rd_pend_d = 1'b1;
          rd_exp_d  = rexp;
          rd_addr_d = addr_q;
          rd_elem_d = elem_q;
        end
        if (!last_op) ph_d = 1'b1;
        else begin
          ph_d = 1'b0;
          if (!last_addr) addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
          else if (elem_q == 3'd5) begin
            addr_d  = '0;
            elem_d  = '0;
            state_d = DRAIN;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = (elem_q >= 3'd2) ? AMAX : '0;
          end
        end
      end
      DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      pat_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      pat_q       <= pat_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_ramdp_bist.sv
// Directed bench for ramdp_bist: behavioural RAM with injectable faults and an op scoreboard.
module tb_ramdp_bist;
  localparam int DW = 8, AW = 2, CW = 2, N = 1 << AW, OPS = 10 * N;

  logic          clk = 1'b0, nreset = 1'b0, start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          ram_en, ram_we, busy, done, fail;
  logic [AW-1:0] ram_addr, fail_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [2:0]    fail_elem;
  logic [CW-1:0] err_count;

  int nerr = 0, nchk = 0;
  int fmode = 0; // 0 clean, 1 addr2 bit0 stuck-at-0, 2 reads inverted

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } op_t;
  op_t sb[$];

  logic [DW-1:0] mem [N];

  ramdp_bist #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .nreset(nreset), .start(start), .pattern(pattern),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .err_count(err_count));

  always #5 clk = ~clk;

  // read-first RAM port: dout always returns the pre-write contents
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr] ^ {DW{fmode == 2}};
      if (ram_we)
        mem[ram_addr] <= (fmode == 1 && ram_addr == 2) ? {ram_din[DW-1:1], 1'b0} : ram_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ops(input logic [DW-1:0] p);
    op_t o;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        o.addr = (e < 3) ? AW'(i) : AW'(N - 1 - i);
        if (e != 0) begin
          o.we = 1'b0; o.din = '0; sb.push_back(o);
        end
        if (e != 5) begin
          o.we = 1'b1; o.din = (e == 1 || e == 3) ? ~p : p; sb.push_back(o);
        end
      end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // start accepted at the next edge (E0); returns just after E(10N+1)
  task automatic run_test(input logic [DW-1:0] p, input bit hold);
    op_t o;
    pattern = p; start = 1'b1;
    push_ops(p);
    step();
    if (!hold) start = 1'b0;
    else pattern = p ^ 8'h3C;
    chk("busy_on_accept", busy, 1);
    chk("done_clr_on_accept", done, 0);
    chk("fail_clr_on_accept", fail, 0);
    chk("err_clr_on_accept", err_count, 0);
    for (int k = 1; k <= OPS; k++) begin
      o = sb.pop_front();
      chk("op_en", ram_en, 1);
      chk("op_we_addr", {ram_we, ram_addr}, {o.we, o.addr});
      if (o.we) chk("op_din", ram_din, o.din);
      step();
    end
    chk("drain_en", ram_en, 0);
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    step();
    if (hold) start = 1'b0;
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("sb_empty", sb.size(), 0);
    step();
    chk("done_sticky", done, 1);
    chk("idle_en", {ram_en, ram_we, ram_addr, ram_din}, 0);
  endtask

  initial begin
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_err", err_count, 0);
    nreset = 1'b1;
    step();

    // clean run, P=0x00
    fmode = 0;
    run_test(8'h00, 1'b0);
    chk("clean_fail", fail, 0);
    chk("clean_err", err_count, 0);

    // P=0xA5
    run_test(8'hA5, 1'b0);
    chk("a5_fail", fail, 0);
    chk("a5_err", err_count, 0);

    // stuck-at-0 on bit 0 of address 2
    fmode = 1;
    run_test(8'h00, 1'b0);
    chk("sa0_fail", fail, 1);
    chk("sa0_addr", fail_addr, 2);
    chk("sa0_elem", fail_elem, 2);
    chk("sa0_err", err_count, 2);

    // start held high throughout, pattern changed mid-run
    run_test(8'h00, 1'b1);
    chk("hold_fail", fail, 1);
    chk("hold_addr", fail_addr, 2);
    chk("hold_err", err_count, 2);

    // new start after a failing run clears status; this run is clean
    fmode = 0;
    run_test(8'h0F, 1'b0);
    chk("rerun_fail", fail, 0);
    chk("rerun_err", err_count, 0);

    // reset asserted at cycle 15 of a run
    pattern = 8'h33; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 15; k++) step();
    chk("mid_busy", busy, 1);
    nreset = 1'b0;
    step();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_fail", fail, 0);
    chk("mr_en", ram_en, 0);
    chk("mr_err", err_count, 0);
    nreset = 1'b1;
    step();
    run_test(8'h33, 1'b0);
    chk("post_rst_fail", fail, 0);

    // every read inverted: counter saturates
    fmode = 2;
    run_test(8'h5C, 1'b0);
    chk("inv_fail", fail, 1);
    chk("inv_err_sat", err_count, 3);
    chk("inv_elem", fail_elem, 1);
    chk("inv_addr", fail_addr, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ramdp_bist.md
Name: ramdp_bist

Overview:
- March C- built-in self-test engine that drives one read/write port of the single-clock dual-port RAM and checks the read data it returns.
- Sits directly upstream of the RAM port. Its en/we/addr/din outputs feed the port inputs, and the port's registered dout feeds back into the engine.
- Runs a complete test on a start pulse and reports pass/fail, the first failing address and march element, and a saturating error count.

Parameters:
- DW, 16, RAM data width.
- AW, 8, RAM address width; N = 2**AW words.
- CW, 8, error-counter width.

Ports:
- clk  input  1  single clock, rising edge.
- nreset  input  1  reset, synchronous, active-low.
- start  input  1  start request; sampled only when idle.
- pattern  input  DW  background word P, latched when start is accepted.
- ram_en  output  1  RAM port enable.
- ram_we  output  1  RAM port write enable.
- ram_addr  output  AW  RAM port address.
- ram_din  output  DW  RAM port write data.
- ram_dout  input  DW  RAM port read data, registered; valid the cycle after a read.
- busy  output  1  test in progress.
- done  output  1  test finished; sticky until next accepted start or reset.
- fail  output  1  at least one miscompare; sticky.
- fail_addr  output  AW  address of first miscompare.
- fail_elem  output  3  march element (0-5) of first miscompare.
- err_count  output  CW  number of miscompares, saturating at 2**CW-1.

Behaviour:
- Reset (nreset=0 at a clk edge): all outputs 0, FSM to IDLE. Reset applies at any time, including mid-test; the RAM contents are then undefined to the bench.
- FSM states: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - start=1 at an edge: latch P, clear done/fail/fail_addr/fail_elem/err_count, set busy=1, go to RUN with elem=0, addr=0.
  - start while busy is ignored.
- RUN: march elements, with 0 meaning P and 1 meaning ~P.
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 down: r0.
  - "up" means address 0..N-1; "down" means N-1..0.
- One RAM op per cycle, with ram_en=1 in every RUN cycle.
  - Read: ram_we=0.
  - Write: ram_we=1, ram_din = P or ~P.
  - Read-then-write at the same address occupies two consecutive cycles.
- Compare: a read issued in cycle k is compared against the expected value during cycle k+1. This holds even when cycle k+1 is the write to the same address, because the RAM updates dout with old data.
- Element transitions: after the last address of an element, move to the next element with its start address, with no idle cycle in between. After the M5 read at address 0, go to DRAIN.
- DRAIN: one cycle, ram_en=0, performs the final compare. At the end of DRAIN: busy=0, done=1, go to IDLE.
- Outside RUN: ram_en=ram_we=0 and ram_addr/ram_din hold 0.
- Latency: with start accepted at edge E0, ops occupy cycles 1..10N, DRAIN is cycle 10N+1, and done rises at edge E(10N+1).
- On a miscompare:
  - err_count increments, saturating.
  - If fail was 0: fail=1 and fail_addr/fail_elem capture the address/element of the failing read. Later miscompares leave them unchanged.
  - The test does not stop early.
- Address counter wraps only at element boundaries; no out-of-range address is ever driven.

Test Plan:
- Clean run, AW=2, DW=8, P=0x00, fault-free RAM -> exactly 40 ram_en cycles, done=1 at E41, busy low after it, fail=0, err_count=0.
- P=0xA5 -> M0 writes 0xA5 to addr 0,1,2,3; M1 writes 0x5A; M3 first op is a read of addr 3; done=1, fail=0.
- Stuck-at-0 on bit 0 of addr 2 (bench model), P=0x00 -> fail=1, fail_addr=2, fail_elem=2, err_count=2 (M2 and M4 reads).
- Assert start every cycle during a run -> run length unchanged (done at E41), pattern and status not re-latched; a new start after done clears done/fail/err_count on acceptance.
- nreset=0 at cycle 15 of a run -> next cycle: busy=done=fail=0, ram_en=0, err_count=0; a subsequent start runs a full 40-op test.
- CW=2, every read inverted by the bench -> err_count saturates at 3, fail_elem=1, fail_addr=0.
